// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared types for the UDP payload frame FIFO
package udp_pkg;

    localparam int UDP_PAYLOAD_WIDTH = 8;

    typedef struct packed {
        logic                         last;
        logic [UDP_PAYLOAD_WIDTH-1:0] data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        DISCARD
    } wr_state_t;

endpackage

// File: rtl/udp_fifo_sdp_ram.sv
// rtl/udp_fifo_sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
module udp_fifo_sdp_ram #(
    parameter int  DEPTH      = 4096,
    parameter int  ADDR_WIDTH = $clog2(DEPTH),
    parameter type entry_t    = logic [8:0]
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  entry_t                wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output entry_t                rdata_o
);

    entry_t mem [DEPTH];

    // rdata_o holds its value when re_i is low; the read pipeline relies on that.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/udp_payload_frame_fifo.sv
// rtl/udp_payload_frame_fifo.sv - store-and-forward datagram FIFO dropping bad/overflowing frames
// Optional counters: UDP_FRAME_FIFO_STATS_EN
module udp_payload_frame_fifo
    import udp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  drop_pulse,
`ifdef UDP_FRAME_FIFO_STATS_EN
    output logic [31:0]           frames_forwarded,
    output logic [15:0]           drops_bad,
    output logic [15:0]           drops_overflow,
`endif
    output logic [ADDR_WIDTH:0]   fifo_level
);

    typedef logic [ADDR_WIDTH:0] ptr_t;
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t PTR_ONE = ptr_t'(1);

    wr_state_t   state_q, state_d;
    ptr_t        wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
    ptr_t        fifo_level_q;
    logic        s_ready_q, drop_q, ram_vld_q, m_vld_q;
    logic        accept, full, ram_we, rd_en, out_load, drop_bad, drop_ovf;
    fifo_entry_t ram_wdata, ram_rdata, m_entry_q;

    udp_fifo_sdp_ram #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .entry_t    (fifo_entry_t)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (ram_wdata),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    // Only committed bytes are fetched; the RAM stage refills when the output register takes its entry.
    always_comb begin
        accept    = s_axis_tvalid & s_ready_q;
        out_load  = ~m_vld_q | m_axis_tready;
        rd_en     = (rd_ptr_q != wr_commit_q) & (~ram_vld_q | out_load);
        rd_ptr_d  = rd_ptr_q + (rd_en ? PTR_ONE : '0);
        full      = (wr_ptr_q - rd_ptr_d) == DEPTH_P;
        ram_wdata = '{last: s_axis_tlast, data: s_axis_tdata};
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        ram_we      = 1'b0;
        drop_bad    = 1'b0;
        drop_ovf    = 1'b0;
        case (state_q)
            IDLE, STORE: begin
                if (accept) begin
                    if (full) begin
                        wr_ptr_d = wr_commit_q;
                        drop_ovf = 1'b1;
                        state_d  = s_axis_tlast ? IDLE : DISCARD;
                    end else if (s_axis_tlast && s_axis_tuser) begin
                        wr_ptr_d = wr_commit_q;
                        drop_bad = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (s_axis_tlast) begin
                            wr_commit_d = wr_ptr_q + PTR_ONE;
                            state_d     = IDLE;
                        end else begin
                            state_d = STORE;
                        end
                    end
                end
            end
            DISCARD: begin
                if (accept && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            wr_commit_q  <= '0;
            rd_ptr_q     <= '0;
            fifo_level_q <= '0;
            s_ready_q    <= 1'b0;
            drop_q       <= 1'b0;
            ram_vld_q    <= 1'b0;
            m_vld_q      <= 1'b0;
            m_entry_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_commit_q  <= wr_commit_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_level_q <= wr_commit_d - rd_ptr_d;
            s_ready_q    <= 1'b1;
            drop_q       <= drop_bad | drop_ovf;
            ram_vld_q    <= rd_en | (ram_vld_q & ~out_load);
            if (out_load) begin
                m_vld_q <= ram_vld_q;
                if (ram_vld_q) begin
                    m_entry_q <= ram_rdata;
                end
            end
        end
    end

`ifdef UDP_FRAME_FIFO_STATS_EN
    logic [31:0] frames_q;
    logic [15:0] drops_bad_q, drops_ovf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frames_q    <= '0;
            drops_bad_q <= '0;
            drops_ovf_q <= '0;
        end else begin
            if (m_vld_q && m_axis_tready && m_entry_q.last) begin
                frames_q <= frames_q + 32'd1;
            end
            if (drop_bad && drops_bad_q != 16'hFFFF) begin
                drops_bad_q <= drops_bad_q + 16'd1;
            end
            if (drop_ovf && drops_ovf_q != 16'hFFFF) begin
                drops_ovf_q <= drops_ovf_q + 16'd1;
            end
        end
    end

    assign frames_forwarded = frames_q;
    assign drops_bad        = drops_bad_q;
    assign drops_overflow   = drops_ovf_q;
`endif

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tdata  = m_entry_q.data;
    assign m_axis_tlast  = m_entry_q.last;
    assign m_axis_tuser  = 1'b0;
    assign drop_pulse    = drop_q;
    assign fifo_level    = fifo_level_q;

endmodule

// File: tb/tb_udp_payload_frame_fifo.sv
// tb/tb_udp_payload_frame_fifo.sv - self-checking bench for udp_payload_frame_fifo
module tb_udp_payload_frame_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic        drop_pulse;
    logic [12:0] fifo_level;
`ifdef UDP_FRAME_FIFO_STATS_EN
    logic [31:0] frames_forwarded;
    logic [15:0] drops_bad, drops_overflow;
`endif

    always #5 clk = ~clk;

    udp_payload_frame_fifo dut (
        .clk              (clk),
        .reset            (reset),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser     (s_axis_tuser),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .drop_pulse       (drop_pulse),
`ifdef UDP_FRAME_FIFO_STATS_EN
        .frames_forwarded (frames_forwarded),
        .drops_bad        (drops_bad),
        .drops_overflow   (drops_overflow),
`endif
        .fifo_level       (fifo_level)
    );

    typedef struct {
        int len;
        bit bad;
        bit fwd;
    } vec_t;

    logic [8:0] sb[$];
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, tlast_cyc = 0;
    int drop_cnt = 0, peak_level = 0, n_out = 0, tready_low = 0;
    int exp_fwd = 0, exp_bad = 0, exp_ovf = 0;
    bit rand_rdy = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard pops, hold-while-stalled checks, drop/level tracking.
    initial begin
        logic       prev_stall;
        logic [8:0] prev_ent, e;
        prev_stall = 1'b0;
        prev_ent   = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_cmp++;
                    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, prev_ent}) begin
                        n_bad++;
                        $display("FAIL hold: got valid %b ent %h, required valid 1 ent %h",
                                 m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, prev_ent);
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    n_cmp++;
                    n_out++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL out_unexpected: got last %b data %h, required no output",
                                 m_axis_tlast, m_axis_tdata);
                    end else begin
                        e = sb.pop_front();
                        if ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== {1'b0, e}) begin
                            n_bad++;
                            $display("FAIL out_beat: got user %b last %b data %h, required user 0 last %b data %h",
                                     m_axis_tuser, m_axis_tlast, m_axis_tdata, e[8], e[7:0]);
                        end
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_ent   = {m_axis_tlast, m_axis_tdata};
                if (drop_pulse) drop_cnt++;
                if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        if (!s_axis_tready) tready_low++;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    // kind: 0 good (forwarded), 1 bad via tuser, 2 expected overflow drop
    task automatic send_frame(input int len, input int kind);
        logic [7:0] seed, d;
        logic       l;
        seed = 8'($urandom_range(1, 200));
        for (int i = 0; i < len; i++) begin
            d = seed + 8'(i);
            l = (i == len - 1);
            if (kind == 0) sb.push_back({l, d});
            send_beat(d, l, l && (kind == 1));
        end
        tlast_cyc = cyc;
        case (kind)
            0: exp_fwd++;
            1: exp_bad++;
            default: exp_ovf++;
        endcase
    endtask

    task automatic drain(input string name);
        rand_rdy      = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 20000 && sb.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check(name, sb.size(), 0);
        check({name, "_idle"}, int'(m_axis_tvalid), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[8];
        int   d0, o0, w;
        vt[0] = '{len: 1,   bad: 1'b0, fwd: 1'b1};
        vt[1] = '{len: 1,   bad: 1'b1, fwd: 1'b0};
        vt[2] = '{len: 2,   bad: 1'b0, fwd: 1'b1};
        vt[3] = '{len: 37,  bad: 1'b1, fwd: 1'b0};
        vt[4] = '{len: 300, bad: 1'b0, fwd: 1'b1};
        vt[5] = '{len: 17,  bad: 1'b0, fwd: 1'b1};
        vt[6] = '{len: 5,   bad: 1'b1, fwd: 1'b0};
        vt[7] = '{len: 129, bad: 1'b0, fwd: 1'b1};

        reset         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        m_axis_tready = 1'b0;

        // Reset values, then tready rises on the first clock after release.
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_tready", int'(s_axis_tready), 0);
        check("rst_m_tvalid", int'(m_axis_tvalid), 0);
        check("rst_m_tdata",  int'(m_axis_tdata), 0);
        check("rst_m_tlast",  int'(m_axis_tlast), 0);
        check("rst_m_tuser",  int'(m_axis_tuser), 0);
        check("rst_drop",     int'(drop_pulse), 0);
        check("rst_level",    int'(fifo_level), 0);
        reset = 1'b1;
        check("rel_tready_before_clk", int'(s_axis_tready), 0);
        @(posedge clk);
        #1;
        check("rel_tready_after_clk", int'(s_axis_tready), 1);

        // Reset mid-datagram with three datagrams committed.
        for (int k = 0; k < 3; k++) send_frame(5, 0);
        send_beat(8'h11, 1'b0, 1'b0);
        send_beat(8'h22, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_valid", int'(m_axis_tvalid), 1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h33;
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_s_tready", int'(s_axis_tready), 0);
        check("mid_rst_m_tvalid", int'(m_axis_tvalid), 0);
        check("mid_rst_m_tdata",  int'(m_axis_tdata), 0);
        check("mid_rst_m_tlast",  int'(m_axis_tlast), 0);
        check("mid_rst_level",    int'(fifo_level), 0);
        sb.delete();
        exp_fwd = 0;
        exp_bad = 0;
        exp_ovf = 0;
        s_axis_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_tready", int'(s_axis_tready), 1);
        check("post_rst_level",  int'(fifo_level), 0);
        check("post_rst_valid",  int'(m_axis_tvalid), 0);
        m_axis_tready = 1'b1;
        send_frame(6, 0);
        drain("post_rst_drain");

        // 64-byte datagram into an empty FIFO: first tvalid two cycles after tlast.
        send_frame(64, 0);
        w = 0;
        while (!m_axis_tvalid && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("latency64", cyc - tlast_cyc, 2);
        drain("drain64");

        // Bad 100-byte datagram then good 10-byte datagram.
        d0 = drop_cnt;
        peak_level = 0;
        send_frame(100, 1);
        send_frame(10, 0);
        drain("drain_bad_good");
        check("bad_drop_count", drop_cnt - d0, 1);
        check("bad_peak_level", peak_level, 10);

        // Table-driven datagrams with random output backpressure.
        rand_rdy = 1'b1;
        foreach (vt[v]) begin
            d0 = drop_cnt;
            send_frame(vt[v].len, vt[v].bad ? 1 : 0);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("vec%0d_drop", v), drop_cnt - d0, vt[v].fwd ? 0 : 1);
        end
        drain("drain_vec");

        // Fill with output stalled; a further datagram overflows and drops.
        m_axis_tready = 1'b0;
        d0 = drop_cnt;
        for (int k = 0; k < 4; k++) send_frame(1024, 0);
        send_frame(20, 2);
        repeat (4) @(posedge clk);
        #1;
        check("full_drop_count", drop_cnt - d0, 1);
        o0 = n_out;
        drain("drain_full");
        check("full_bytes_out", n_out - o0, 4096);

        // Datagram longer than the buffer always drops; the next one passes.
        d0 = drop_cnt;
        tready_low = 0;
        o0 = n_out;
        send_frame(5000, 2);
        send_frame(8, 0);
        drain("drain_long");
        check("long_drop_count", drop_cnt - d0, 1);
        check("long_tready_low", tready_low, 0);
        check("long_bytes_out", n_out - o0, 8);

`ifdef UDP_FRAME_FIFO_STATS_EN
        check("stats_forwarded", int'(frames_forwarded), exp_fwd);
        check("stats_drops_bad", int'(drops_bad), exp_bad);
        check("stats_drops_ovf", int'(drops_overflow), exp_ovf);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/udp_payload_frame_fifo.md
Name: udp_payload_frame_fifo

Overview:
- Store-and-forward datagram FIFO on the UDP payload path.
- Sits directly downstream of the UDP stack's received-payload AXI-Stream and feeds the stack's transmit-payload input, making up the echo/loopback path.
- Forwards only complete, error-free datagrams. Drops any datagram flagged bad (tuser on tlast) or one that overflows the buffer, so the transmit side never sees a truncated payload.

Parameters:
- DATA_WIDTH, 8, payload byte width; only 8 is supported.
- DEPTH, 4096, buffer entries; must be a power of two and at least 2048.
- ADDR_WIDTH, $clog2(DEPTH), derived; do not override.

Ports:
- clk  input  1  sole clock; both streams are synchronous to it
- reset  input  1  asynchronous, active-low reset
- s_axis_tdata  input  8  received payload byte
- s_axis_tvalid  input  1  input beat valid
- s_axis_tready  output  1  input ready
- s_axis_tlast  input  1  last byte of datagram
- s_axis_tuser  input  1  bad-datagram flag; sampled on the tlast beat only
- m_axis_tdata  output  8  forwarded byte
- m_axis_tvalid  output  1  output beat valid
- m_axis_tready  input  1  downstream ready
- m_axis_tlast  output  1  last byte of forwarded datagram
- m_axis_tuser  output  1  always 0
- drop_pulse  output  1  one-cycle pulse per dropped datagram
- fifo_level  output  ADDR_WIDTH+1  committed entries not yet read

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, drop_pulse=0, fifo_level=0. All pointers are cleared.
- s_axis_tready is registered. It is 0 during reset and goes to 1 on the first clock after reset deasserts, then stays 1; the block never backpressures.
- Storage: each entry holds {tlast, tdata}, 9 bits. Pointers are ADDR_WIDTH+1 bits, wrap modulo 2*DEPTH, and use MSB-differs full/empty detection.
- Write side has three pointers: wr_ptr (speculative), wr_commit (last committed boundary), rd_ptr.
- Write FSM states: IDLE, STORE, DISCARD.
  - IDLE: the first accepted beat moves to STORE.
  - STORE, accepted beat with space: write at wr_ptr, wr_ptr++.
  - STORE, beat with tlast=1 and tuser=0: write, then wr_commit <= wr_ptr+1, go to IDLE.
  - STORE, beat with tlast=1 and tuser=1: wr_ptr <= wr_commit, pulse drop_pulse, go to IDLE.
  - STORE, beat arrives while wr_ptr-rd_ptr == DEPTH (full): wr_ptr <= wr_commit and pulse drop_pulse. If that beat has tlast, go to IDLE; otherwise go to DISCARD.
  - DISCARD: accept and discard beats until tlast, then go to IDLE. No second drop_pulse.
  - Single-beat datagram (tlast on the first beat) is handled directly from IDLE with the same rules.
- Read side:
  - Readable when rd_ptr != wr_commit. Uncommitted bytes are never visible.
  - Synchronous RAM read followed by one output register. The output register reloads when it is empty or when m_axis_tvalid and m_axis_tready are both high.
  - Latency: a tlast beat accepted at cycle N gives m_axis_tvalid=1 at N+2 at the earliest, provided the FIFO was empty.
  - Sustained throughput is 1 beat/cycle with m_axis_tready held high.
  - m_axis_tvalid and m_axis_tdata hold stable while m_axis_tready=0.
- Commit and read may occur in the same cycle; fifo_level = wr_commit - rd_ptr, registered.
- Full is judged against rd_ptr including reads in the same cycle: a simultaneous read frees space.
- A datagram longer than DEPTH always drops, whatever else is in the buffer.

Optional Feature:
- Macro: UDP_FRAME_FIFO_STATS_EN.
- When defined, three extra outputs are added:
  - frames_forwarded, 32 bits, increments on each m_axis tlast handshake.
  - drops_bad, 16 bits, saturating at 0xFFFF, counts tuser drops.
  - drops_overflow, 16 bits, saturating at 0xFFFF, counts overflow drops.
- All three reset to 0.
- When not defined, these ports and counters do not exist; drop_pulse is unchanged.

Decomposition:
- Package udp_pkg holds:
  - localparam UDP_PAYLOAD_WIDTH = 8.
  - typedef fifo_entry_t, a packed struct {logic last; logic [7:0] data;}.
  - typedef enum wr_state_t {IDLE, STORE, DISCARD}.
- Sub-module udp_fifo_sdp_ram: simple dual-port RAM, one write port and one registered read port, parameterised by depth and entry type. No reset on the array.

Test Plan:
- 64-byte datagram, tuser=0, m_axis_tready=1 -> the same 64 bytes out, tlast on byte 64, first m_axis_tvalid 2 cycles after input tlast.
- 100-byte datagram with tuser=1 on tlast, then 10-byte good datagram -> only the 10 bytes emerge; drop_pulse exactly once; fifo_level peaks at 10.
- m_axis_tready=0, stream 4096 good bytes as 4 x 1024 datagrams, then one 20-byte datagram -> 20-byte datagram dropped (one drop_pulse); release ready -> 4096 bytes out intact.
- 5000-byte datagram into empty FIFO -> dropped; DISCARD consumes the rest; s_axis_tready stays 1; following 8-byte datagram forwarded.
- Reset asserted mid-datagram with 3 datagrams committed -> all outputs at reset values immediately; after release the FIFO is empty and the next datagram passes.
- With UDP_FRAME_FIFO_STATS_EN: 3 good, 2 bad, 1 overflow -> frames_forwarded=3, drops_bad=2, drops_overflow=1.
